// File: rtl/prbs7_checker.sv
// ----------------------------------------------------------------------------
// prbs7_checker
//
// Self-synchronizing PRBS7 (x^7 + x^6 + 1) checker for the receive side of the
// SERDES link. Aligned words are consumed LSB-first; every bit is predicted
// from the seven bits received just before it (p[n] = s[n-7] ^ s[n-6]), so the
// checker needs no seed and locks onto any phase of the transmitted sequence.
// A three-state FSM (IDLE / ACQUIRE / LOCKED) tracks lock, and two saturating
// counters accumulate bit and word errors while locked, for BER measurement.
//
// Ports:
//   clk          receive word clock
//   reset        synchronous, active-high; clears all state and outputs
//   din          aligned data word, din[0] is the earliest bit in time
//   din_valid    word valid; a low cycle drops the checker back to IDLE
//   clr_cnt      synchronous clear of both error counters (beats increment)
//   locked       checker is in LOCKED
//   err_word     last checked word contained at least one error
//   err_mask     per-bit error flags of the last checked word
//   bit_err_cnt  accumulated bit errors while locked, saturating
//   word_err_cnt accumulated errored words while locked, saturating
// ----------------------------------------------------------------------------
module prbs7_checker #(
    parameter int WORDWIDTH    = 32,
    parameter int ERRCNT_WIDTH = 16,
    parameter int LOCK_WORDS   = 4,
    parameter int UNLOCK_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WORDWIDTH-1:0]    din,
    input  logic                    din_valid,
    input  logic                    clr_cnt,
    output logic                    locked,
    output logic                    err_word,
    output logic [WORDWIDTH-1:0]    err_mask,
    output logic [ERRCNT_WIDTH-1:0] bit_err_cnt,
    output logic [ERRCNT_WIDTH-1:0] word_err_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int PC_W  = $clog2(WORDWIDTH + 1);
    localparam int SUM_W = ((ERRCNT_WIDTH > PC_W) ? ERRCNT_WIDTH : PC_W) + 1;
    localparam logic [ERRCNT_WIDTH-1:0] CNT_MAX = '1;

    state_t      state, state_nxt;
    logic [6:0]  hist, hist_nxt;          // previous word bits [W-7..W-1]
    logic [3:0]  clean_run, clean_run_nxt;
    logic [3:0]  bad_run, bad_run_nxt;

    // Stream view: ext[j] is bit s[j-7] relative to the current word, so
    // ext[k] = s[k-7] and ext[k+1] = s[k-6]. Only the low W-6 bits of din are
    // ever used as predictors.
    logic [WORDWIDTH:0]   ext;
    logic [WORDWIDTH-1:0] pred;
    logic [WORDWIDTH-1:0] chk_mask;
    logic                 chk_err;
    logic                 zero_word;
    logic [PC_W-1:0]      pop;

    logic                    check_en;
    logic                    count_en;
    logic [SUM_W-1:0]        bit_sum;
    logic [ERRCNT_WIDTH-1:0] bit_cnt_inc;
    logic [ERRCNT_WIDTH-1:0] word_cnt_inc;

    assign ext = {din[WORDWIDTH-7:0], hist};

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        pred = '0;
        for (int k = 0; k < WORDWIDTH; k++) begin
            pred[k] = ext[k] ^ ext[k+1];
        end
    end

    // An all-zero word on an all-zero history satisfies the recurrence, so it
    // is flagged explicitly to keep the checker out of the zero lockup.
    assign zero_word = (din == '0) && (hist == '0);
    assign chk_mask  = zero_word ? '0 : (din ^ pred);
    assign chk_err   = zero_word || (|chk_mask);

    always_comb begin
        pop = '0;
        for (int i = 0; i < WORDWIDTH; i++) begin
            pop = pop + PC_W'(chk_mask[i]);
        end
    end

    // Saturating increments, computed one bit wider than needed so the
    // overflow test cannot itself wrap.
    assign bit_sum      = SUM_W'(bit_err_cnt) + SUM_W'(pop);
    assign bit_cnt_inc  = (bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX
                                                      : bit_sum[ERRCNT_WIDTH-1:0];
    assign word_cnt_inc = (chk_err && (word_err_cnt != CNT_MAX))
                          ? word_err_cnt + 1'b1 : word_err_cnt;

    // ---------------------------------------------------------------- state
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from the values seen before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hist      <= '0;
            clean_run <= '0;
            bad_run   <= '0;
        end else begin
            state     <= state_nxt;
            hist      <= hist_nxt;
            clean_run <= clean_run_nxt;
            bad_run   <= bad_run_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_nxt     = state;
        hist_nxt      = hist;
        clean_run_nxt = clean_run;
        bad_run_nxt   = bad_run;

        if (!din_valid) begin
            // A gap breaks bit continuity: history is no longer trustworthy.
            state_nxt     = IDLE;
            hist_nxt      = '0;
            clean_run_nxt = '0;
            bad_run_nxt   = '0;
        end else begin
            hist_nxt = din[WORDWIDTH-1 -: 7];
            unique case (state)
                IDLE: begin
                    state_nxt     = ACQUIRE;
                    clean_run_nxt = '0;
                    bad_run_nxt   = '0;
                end
                ACQUIRE: begin
                    if (chk_err) begin
                        clean_run_nxt = '0;
                    end else if (clean_run == 4'(LOCK_WORDS - 1)) begin
                        state_nxt     = LOCKED;
                        clean_run_nxt = '0;
                        bad_run_nxt   = '0;
                    end else begin
                        clean_run_nxt = clean_run + 4'd1;
                    end
                end
                LOCKED: begin
                    if (!chk_err) begin
                        bad_run_nxt = '0;
                    end else if (bad_run == 4'(UNLOCK_WORDS - 1)) begin
                        state_nxt     = ACQUIRE;
                        clean_run_nxt = '0;
                        bad_run_nxt   = '0;
                    end else begin
                        bad_run_nxt = bad_run + 4'd1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        locked   = (state == LOCKED);
        check_en = din_valid && (state != IDLE);
        count_en = din_valid && (state == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_mask     <= '0;
            err_word     <= 1'b0;
            bit_err_cnt  <= '0;
            word_err_cnt <= '0;
        end else begin
            if (check_en) begin
                err_mask <= chk_mask;
                err_word <= chk_err;
            end else begin
                err_mask <= '0;
                err_word <= 1'b0;
            end

            if (clr_cnt) begin
                bit_err_cnt  <= '0;
                word_err_cnt <= '0;
            end else if (count_en) begin
                bit_err_cnt  <= bit_cnt_inc;
                word_err_cnt <= word_cnt_inc;
            end
        end
    end

endmodule

// File: tb/tb_prbs7_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs7_checker
//
// Directed bench for prbs7_checker. A driver applies one word per cycle and
// pushes the expected response into a queue; a monitor pops one entry after
// every clock edge and compares. Two instances share the stimulus: the main
// one with 16-bit counters and one with 4-bit counters for saturation.
// ----------------------------------------------------------------------------
module tb_prbs7_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_valid;
    logic        clr_cnt;

    logic        locked, err_word;
    logic [31:0] err_mask;
    logic [15:0] bit_err_cnt, word_err_cnt;

    logic        s_locked, s_err_word;
    logic [31:0] s_err_mask;
    logic [3:0]  s_bit_err_cnt, s_word_err_cnt;

    always #5 clk = ~clk;

    prbs7_checker #(.WORDWIDTH(32), .ERRCNT_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .clr_cnt      (clr_cnt),
        .locked       (locked),
        .err_word     (err_word),
        .err_mask     (err_mask),
        .bit_err_cnt  (bit_err_cnt),
        .word_err_cnt (word_err_cnt)
    );

    prbs7_checker #(.WORDWIDTH(32), .ERRCNT_WIDTH(4)) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_valid    (din_valid),
        .clr_cnt      (clr_cnt),
        .locked       (s_locked),
        .err_word     (s_err_word),
        .err_mask     (s_err_mask),
        .bit_err_cnt  (s_bit_err_cnt),
        .word_err_cnt (s_word_err_cnt)
    );

    typedef struct {
        logic [31:0] mask;
        logic        err;
        logic        lk;
        logic [15:0] b;
        logic [15:0] w;
        logic [3:0]  b4;
        logic [3:0]  w4;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_x;
    int          total = 0;
    int          bad   = 0;
    int          e_b, e_w, e_b4, e_w4;
    logic [6:0]  sr = 7'h7F;
    logic [31:0] last_din;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, got, want, $time);
        end
    endtask

    // Next 32 bits of the PRBS7 stream, LSB = earliest; s[n] = s[n-7] ^ s[n-6].
    task automatic gen_word(output logic [31:0] w);
        logic nb;
        for (int i = 0; i < 32; i++) begin
            w[i] = sr[0];
            nb   = sr[0] ^ sr[1];
            sr   = {nb, sr[6:1]};
        end
    endtask

    task automatic add_err(input int nb, input int nw);
        e_b  += nb;
        e_w  += nw;
        e_b4 = (e_b4 + nb > 15) ? 15 : e_b4 + nb;
        e_w4 = (e_w4 + nw > 15) ? 15 : e_w4 + nw;
    endtask

    task automatic clr_exp();
        e_b = 0; e_w = 0; e_b4 = 0; e_w4 = 0;
    endtask

    // Drive one cycle and queue what the outputs must show after the edge.
    task automatic send(input logic [31:0] d, input logic v, input logic c, input logic r,
                        input logic [31:0] m, input logic e, input logic l);
        exp_t x;
        @(negedge clk);
        din       = d;
        din_valid = v;
        clr_cnt   = c;
        reset     = r;
        x.mask = m;
        x.err  = e;
        x.lk   = l;
        x.b    = 16'(e_b);
        x.w    = 16'(e_w);
        x.b4   = 4'(e_b4);
        x.w4   = 4'(e_w4);
        sb_q.push_back(x);
        if (v) last_din = d;
    endtask

    task automatic clean(input logic l);
        logic [31:0] w;
        gen_word(w);
        send(w, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, l);
    endtask

    // Priming word plus LOCK_WORDS clean words; lock appears with the 5th.
    task automatic relock();
        for (int i = 0; i < 5; i++) clean(i == 4);
    endtask

    // Mask of an all-zero word following prev: bit k flags s[k-7] ^ s[k-6].
    function automatic logic [31:0] zmask(input logic [31:0] prev);
        logic [38:0] s;
        logic [31:0] m;
        s = {32'h0, prev[31:25]};
        m = '0;
        for (int k = 0; k < 32; k++) m[k] = s[k] ^ s[k+1];
        return m;
    endfunction

    // Monitor: one scoreboard entry per clock edge, sampled 1 time unit later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_x = sb_q.pop_front();
                check("err_mask",     err_mask,                 mon_x.mask);
                check("err_word",     32'(err_word),            32'(mon_x.err));
                check("locked",       32'(locked),              32'(mon_x.lk));
                check("bit_err_cnt",  32'(bit_err_cnt),         32'(mon_x.b));
                check("word_err_cnt", 32'(word_err_cnt),        32'(mon_x.w));
                check("sat_locked",   32'(s_locked),            32'(mon_x.lk));
                check("sat_err_word", 32'(s_err_word),          32'(mon_x.err));
                check("sat_err_mask", s_err_mask,               mon_x.mask);
                check("sat_bit_cnt",  32'(s_bit_err_cnt),       32'(mon_x.b4));
                check("sat_word_cnt", 32'(s_word_err_cnt),      32'(mon_x.w4));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] w;
        logic [31:0] m;
        int          n;
        reset = 1'b1; din_valid = 1'b0; clr_cnt = 1'b0; din = '0;
        last_din = '0;
        clr_exp();

        // Reset state.
        send(32'h0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        send(32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);

        // Clean stream: locked from the 5th word, counters stay 0.
        for (int i = 0; i < 1000; i++) clean(i >= 4);

        // Single flip at bit 0: flags at 0, 6, 7 of the same word.
        gen_word(w);
        add_err(3, 1);
        send(w ^ 32'h1, 1'b1, 1'b0, 1'b0, 32'h0000_00C1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) clean(1'b1);

        // Flip at bit 31: flag at 31, then bits 5 and 6 of the next word.
        gen_word(w);
        add_err(1, 1);
        send(w ^ 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        gen_word(w);
        add_err(2, 1);
        send(w, 1'b1, 1'b0, 1'b0, 32'h0000_0060, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) clean(1'b1);

        // Repeated errors drive the 4-bit counters into saturation.
        for (int i = 0; i < 14; i++) begin
            gen_word(w);
            add_err(3, 1);
            send(w ^ 32'h1, 1'b1, 1'b0, 1'b0, 32'h0000_00C1, 1'b1, 1'b1);
            clean(1'b1);
        end

        // clr_cnt in the same cycle as an errored word wins.
        gen_word(w);
        clr_exp();
        send(w ^ 32'h1, 1'b1, 1'b1, 1'b0, 32'h0000_00C1, 1'b1, 1'b1);
        clean(1'b1);
        clean(1'b1);

        // Six zero words: recurrence flags the first, zero-word rule the rest;
        // unlock on the 4th, counting stops afterwards, no relock on zeros.
        m = zmask(last_din);
        add_err($countones(m), 1);
        send(32'h0, 1'b1, 1'b0, 1'b0, m, 1'b1, 1'b1);
        add_err(0, 1);
        send(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        add_err(0, 1);
        send(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        add_err(0, 1);
        send(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        send(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        send(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Gap returns to IDLE; stream relocks with counters untouched.
        send(32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        relock();
        clean(1'b1);
        clean(1'b1);

        // One-cycle valid drop while locked.
        send(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        relock();
        clean(1'b1);
        clean(1'b1);

        // Reset mid-stream with an errored word present: everything clears.
        gen_word(w);
        clr_exp();
        send(w ^ 32'h1, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
        relock();
        clean(1'b1);

        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #3;
        check("scoreboard_drain", 32'(sb_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prbs7_checker.md
# prbs7_checker

Self-synchronizing PRBS7 (x^7 + x^6 + 1) checker placed directly downstream of the `dataExtract` word aligner on the receive side of the SERDES link. It consumes aligned 32-bit words LSB-first and predicts each bit from the seven preceding received bits. It then acquires and tracks lock and accumulates saturating bit-error and word-error counts for link BER measurement. It closes the loop against the transmit-side `PRBS7` generator.

## Interface
Parameters:
- `WORDWIDTH`, 32: data word width; legal range 8..64.
- `ERRCNT_WIDTH`, 16: width of both error counters.
- `LOCK_WORDS`, 4: consecutive clean checked words required to lock (1..15).
- `UNLOCK_WORDS`, 4: consecutive errored words in LOCKED that force unlock (1..15).

Ports:
- `clk`  in  1: receive word clock (`recClk` domain). One clock; no other clocks.
- `reset`  in  1: synchronous, active-high. Clears all state and outputs.
- `din`  in  WORDWIDTH: aligned word; `din[0]` is the earliest bit in time.
- `din_valid`  in  1: word valid; driven from `aligned`.
- `clr_cnt`  in  1: synchronous clear of both error counters.
- `locked`  out  1: checker in LOCKED state.
- `err_word`  out  1: the last checked word contained at least one error.
- `err_mask`  out  WORDWIDTH: per-bit error flags of the last checked word.
- `bit_err_cnt`  out  ERRCNT_WIDTH: accumulated bit errors, saturating.
- `word_err_cnt`  out  ERRCNT_WIDTH: accumulated errored words, saturating.

## Operation
- Stream bits s[n], ordered LSB-first within a word, across successive valid words.
- Prediction: p[k] = s[k-7] ^ s[k-6], using received bits only.
  - For bits 0..6 of a word, the prediction uses a 7-bit history register holding the previous valid word's bits [W-7..W-1].
  - `err_mask[k]` = `din[k]` ^ p[k].
- Zero-lockup rule: a word is a zero word when `din` == 0 and history == 0.
  - A zero word sets `err_word`=1 with `err_mask`=0.
  - It increments `word_err_cnt` only; `bit_err_cnt` is unchanged.
- A single flipped bit at position n produces three flags: at n, n+6 and n+7. This is intended and is not corrected.
- FSM states:
  - IDLE: no history. The first valid word only loads history, is not checked, and moves the FSM to ACQUIRE.
  - ACQUIRE: each valid word is checked. Consecutive clean words are counted; any errored word resets that count to 0. When the count reaches LOCK_WORDS, the FSM moves to LOCKED.
  - LOCKED: consecutive errored words are counted; a clean word resets that count. When the count reaches UNLOCK_WORDS, the FSM moves to ACQUIRE, with history kept and the clean count at 0.
  - `din_valid`=0 in any state moves the FSM to IDLE at the next edge. History is invalidated and both run counters are cleared.
- Counters update only for words checked while in LOCKED, including the word that causes unlock.
  - `bit_err_cnt` += popcount(`err_mask`); `word_err_cnt` += `err_word`.
  - Both counters saturate at all-ones and never wrap.
  - `clr_cnt` forces both counters to 0. `clr_cnt` beats a same-cycle increment.
- In IDLE, `err_mask` and `err_word` are written as 0 on priming words and when `din_valid`=0.

## Timing
- Reset values: `locked`=0, `err_word`=0, `err_mask`=0, both counters 0, FSM in IDLE, history 0.
- `reset` takes priority over all other inputs.
- Latency: a word sampled at edge t appears on `err_mask`/`err_word` after edge t. The counters reflect that word after the same edge, so latency is 1 cycle.
- `locked` rises at the same edge that registers the LOCK_WORDS-th clean word. It falls at the edge that registers the UNLOCK_WORDS-th consecutive errored word, or at the edge after `din_valid` drops.
- All outputs are registered. No combinational path runs from inputs to outputs.
- Full throughput: one word per cycle, with no stall.

## Test plan
- Clean stream: PRBS7 with seed 7'h7F packed into 32-bit words, `din_valid`=1 from cycle 0.
  - `locked` must be 1 after edge 5 (1 priming word + 4 clean words).
  - Both counters must be 0 after 1000 words.
- Flip `din[0]` of one word while locked.
  - That word's `err_mask` must be 32'h000000C1.
  - `bit_err_cnt` must go +3 and `word_err_cnt` must go +1.
  - `locked` must stay 1.
- Flip `din[31]` of word w while locked.
  - Word w must show `err_mask`=32'h80000000.
  - Word w+1 must show 32'h00000060.
  - `bit_err_cnt` must go +3 and `word_err_cnt` must go +2.
- Force `din`=0 for 6 words after lock.
  - The first word is flagged by the recurrence.
  - The following words are flagged as zero words.
  - `locked` must fall after the 4th errored word.
  - `word_err_cnt` must be 4, because counting stops once unlocked.
  - The FSM must not relock on the zeros.
- Preload the counters near saturation: `ERRCNT_WIDTH`=4, inject repeated errors.
  - Both counters must hold at 4'hF.
  - `clr_cnt` pulsed in the same cycle as an error must leave the counters at 0.
- Drop `din_valid` for 1 cycle while locked, then resume with a continuous stream; assert `reset` mid-stream.
  - After the `din_valid` drop: `locked` must fall the next cycle and relock after 5 valid words, with counters unchanged.
  - After `reset`: all outputs must be 0 at the next edge.
